// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin byte scheduler feeding a UART transmit CSR
//
// Purpose:
//   Arbitrates up to four byte requesters onto a single UART transmit CSR.
//   A winner is picked round-robin, its byte is written with a single
//   csr_we pulse, and the scheduler then waits for the UART's tx_irq
//   before it picks the next requester.
//
// Parameters:
//   csr_addr  UART CSR bank select, placed on csr_a[13:10]
//   TIMEOUT   max sys_clk cycles spent waiting for tx_irq (timeout build only)
//
// Ports:
//   sys_clk   in   1   clock, all logic on the rising edge
//   sys_rst   in   1   synchronous active-high reset
//   req       in   4   per-requester byte-pending flags
//   req_data  in   32  requester i byte on [8i+7:8i]
//   gnt       out  4   one-hot single-cycle accept pulse
//   csr_a     out  14  UART CSR address
//   csr_we    out  1   UART CSR write strobe
//   csr_di    out  32  UART CSR write data
//   tx_irq    in   1   UART transmit-done pulse
//   busy      out  1   scheduler not idle
//   err       out  1   sticky transmit timeout flag
//
// Build option:
//   UART_TX_SCHED_TIMEOUT_EN  adds the WAIT timeout counter and the err flag;
//                             when undefined WAIT exits only on tx_irq and
//                             err is tied low.

module uart_tx_sched #(
  parameter logic [3:0]  csr_addr = 4'h0,
  parameter logic [23:0] TIMEOUT  = 24'd1048576
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  gnt,
  output logic [13:0] csr_a,
  output logic        csr_we,
  output logic [31:0] csr_di,
  input  logic        tx_irq,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic        csr_we_q, csr_we_d;
  logic [13:0] csr_a_q, csr_a_d;
  logic [31:0] csr_di_q, csr_di_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  win_q, win_d;

  // Round-robin candidate search results
  logic        win_found;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic [7:0]  win_byte;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [23:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        tmo_hit;

  assign tmo_hit = (cnt_q == (TIMEOUT - 24'd1));
`else
  // TIMEOUT only matters for the timeout build
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Search starts one past the last serviced requester so that every
  // pending requester is reached within four transfers.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = last_q + 2'(k + 1);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_byte = req_data[{win_idx, 3'b000} +: 8];

  // State register (all flops)
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 4'd0;
      csr_we_q <= 1'b0;
      csr_a_q  <= 14'd0;
      csr_di_q <= 32'd0;
      last_q   <= 2'd3;
      win_q    <= 2'd0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      cnt_q    <= 24'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      csr_we_q <= csr_we_d;
      csr_a_q  <= csr_a_d;
      csr_di_q <= csr_di_d;
      last_q   <= last_d;
      win_q    <= win_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_irq) begin
          state_d = ST_IDLE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    gnt_d    = 4'd0;
    csr_we_d = 1'b0;
    csr_a_d  = csr_a_q;
    csr_di_d = csr_di_q;
    last_d   = last_q;
    win_d    = win_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gnt_d    = 4'b0001 << win_idx;
          csr_we_d = 1'b1;
          csr_a_d  = {csr_addr, 10'd0};
          csr_di_d = {24'd0, win_byte};
          win_d    = win_idx;
        end
      end
      ST_ISSUE: begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Counter starts from zero on the first WAIT cycle
        cnt_d = 24'd0;
`endif
      end
      ST_WAIT: begin
        if (tx_irq) begin
          // A completion in the timeout cycle is still a normal completion
          last_d = win_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        end else if (tmo_hit) begin
          last_d = win_q;
          err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 24'd1;
`endif
        end
      end
      default: ;
    endcase
  end

  assign gnt    = gnt_q;
  assign csr_we = csr_we_q;
  assign csr_a  = csr_a_q;
  assign csr_di = csr_di_q;
  assign busy   = (state_q != ST_IDLE);

`ifdef UART_TX_SCHED_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
